// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage_if
// Purpose  : Pipeline-control, instruction-memory and IF/ID bundle of the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_stage_if;
    logic        if_stall;
    logic        if_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    // master: the fetch stage itself; slave: controller, memory and IF/ID side
    modport master (
        input  if_stall, if_flush, redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output imem_req_valid, imem_req_addr,
        output id_valid, id_pc, id_instr
    );

    modport slave (
        output if_stall, if_flush, redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  imem_req_valid, imem_req_addr,
        input  id_valid, id_pc, id_instr
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : RV32 fetch stage: PC owner, in-order imem requests, 2-entry queue.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    if_fetch_stage_if.master bus
);
    localparam logic [31:0] c_ADDR_INC = 32'd4;

    logic [31:0] r_pc;
    logic        r_run;
    logic [31:0] r_q_pc    [2];
    logic [31:0] r_q_instr [2];
    logic [1:0]  r_q_filled;
    logic        r_alloc_ptr;
    logic        r_fill_ptr;
    logic        r_head_ptr;
    logic [1:0]  r_count;
    logic [1:0]  r_drop_cnt;

    logic        w_kill;
    logic        w_id_valid;
    logic        w_deq;
    logic        w_req_valid;
    logic        w_accept;
    logic [2:0]  w_occ;
    logic [1:0]  w_filled_cnt;
    logic [1:0]  w_unfilled;
    logic [2:0]  w_kill_drop;

    assign w_kill     = bus.if_flush | bus.redirect_valid;
    // filled bits are cleared whenever an entry leaves the queue, so the head bit alone is enough
    assign w_id_valid = r_q_filled[r_head_ptr] & ~w_kill;
    assign w_deq      = w_id_valid & ~bus.if_stall;

    assign w_occ       = {1'b0, r_count} + {1'b0, r_drop_cnt};
    assign w_req_valid = r_run & ((w_occ < 3'd2) | ((w_occ == 3'd2) & w_deq));
    assign w_accept    = w_req_valid & bus.imem_req_ready;

    assign w_filled_cnt = {1'b0, r_q_filled[0]} + {1'b0, r_q_filled[1]};
    assign w_unfilled   = r_count - w_filled_cnt;
    // every allocated-but-unfilled entry and any same-cycle accept becomes a response to discard
    assign w_kill_drop  = {1'b0, r_drop_cnt} + {1'b0, w_unfilled}
                        + {2'b00, w_accept} - {2'b00, bus.imem_rsp_valid};

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.id_valid       = w_id_valid;
    assign bus.id_pc          = r_q_pc[r_head_ptr];
    assign bus.id_instr       = r_q_instr[r_head_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_run        <= 1'b0;
            r_q_pc[0]    <= 32'h0;
            r_q_pc[1]    <= 32'h0;
            r_q_instr[0] <= 32'h0;
            r_q_instr[1] <= 32'h0;
            r_q_filled   <= 2'b00;
            r_alloc_ptr  <= 1'b0;
            r_fill_ptr   <= 1'b0;
            r_head_ptr   <= 1'b0;
            r_count      <= 2'd0;
            r_drop_cnt   <= 2'd0;
        end else begin
            r_run <= 1'b1;
            if (w_kill) begin
                r_pc        <= {bus.redirect_pc[31:2], 2'b00};
                r_q_filled  <= 2'b00;
                r_alloc_ptr <= 1'b0;
                r_fill_ptr  <= 1'b0;
                r_head_ptr  <= 1'b0;
                r_count     <= 2'd0;
                r_drop_cnt  <= w_kill_drop[1:0];
            end else begin
                if (w_deq) begin
                    r_q_filled[r_head_ptr] <= 1'b0;
                    r_head_ptr             <= ~r_head_ptr;
                end
                // when full with a dequeue, the allocation reuses the slot just vacated
                if (w_accept) begin
                    r_q_pc[r_alloc_ptr]     <= r_pc;
                    r_q_filled[r_alloc_ptr] <= 1'b0;
                    r_alloc_ptr             <= ~r_alloc_ptr;
                    r_pc                    <= r_pc + c_ADDR_INC;
                end
                if (bus.imem_rsp_valid) begin
                    if (r_drop_cnt != 2'd0) begin
                        r_drop_cnt <= r_drop_cnt - 2'd1;
                    end else begin
                        r_q_instr[r_fill_ptr]  <= bus.imem_rsp_data;
                        r_q_filled[r_fill_ptr] <= 1'b1;
                        r_fill_ptr             <= ~r_fill_ptr;
                    end
                end
                r_count <= r_count + {1'b0, w_accept} - {1'b0, w_deq};
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Randomized and directed checks of if_fetch_stage against a stream-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int lat    = 1;

    logic        st_rstn, st_stall, st_flush, st_redir, st_ready;
    logic [31:0] st_rpc;

    // model: next fetch address, next expected program-order PC at IF/ID
    logic [31:0] m_fpc, m_exp;
    logic        hold_v;
    logic [31:0] hold_pc, hold_instr;
    mreq_t       mq[$];
    logic [31:0] deq_log[$];

    logic        s_req_valid, s_id_valid;
    logic [31:0] s_req_addr, s_id_pc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic kill, deq, acc, rsp;
        mreq_t e;
        @(negedge clk);
        rst_n              = st_rstn;
        bus.if_stall       = st_stall;
        bus.if_flush       = st_flush;
        bus.redirect_valid = st_redir;
        bus.redirect_pc    = st_rpc;
        bus.imem_req_ready = st_ready;
        rsp                = 1'b0;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        if (st_rstn && mq.size() > 0) begin
            if (mq[0].due <= cyc) begin
                rsp               = 1'b1;
                bus.imem_rsp_data = memf(mq[0].addr);
            end
        end
        bus.imem_rsp_valid = rsp;
        #1;
        s_req_valid = bus.imem_req_valid;
        s_req_addr  = bus.imem_req_addr;
        s_id_valid  = bus.id_valid;
        s_id_pc     = bus.id_pc;
        if (!st_rstn) begin
            chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
            chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
            m_fpc  = RESET_PC;
            m_exp  = RESET_PC;
            hold_v = 1'b0;
            mq.delete();
        end else begin
            kill = st_flush | st_redir;
            deq  = bus.id_valid & ~st_stall;
            acc  = bus.imem_req_valid & st_ready;
            chk("req_addr", bus.imem_req_addr, m_fpc);
            chk("inflight_le2", 32'(mq.size() <= 2), 32'd1);
            if (kill) chk("id_valid_kill", 32'(bus.id_valid), 32'd0);
            if (hold_v && !kill) begin
                chk("hold_valid", 32'(bus.id_valid), 32'd1);
                chk("hold_pc", bus.id_pc, hold_pc);
                chk("hold_instr", bus.id_instr, hold_instr);
            end
            if (bus.id_valid) begin
                chk("id_pc", bus.id_pc, m_exp);
                chk("id_instr", bus.id_instr, memf(m_exp));
            end
            if (rsp) void'(mq.pop_front());
            if (acc) begin
                e.addr = bus.imem_req_addr;
                e.due  = cyc + lat;
                mq.push_back(e);
            end
            hold_v     = bus.id_valid & st_stall;
            hold_pc    = m_exp;
            hold_instr = memf(m_exp);
            if (deq) begin
                deq_log.push_back(bus.id_pc);
                m_exp = m_exp + 32'd4;
            end
            if (kill) begin
                m_fpc = {st_rpc[31:2], 2'b00};
                m_exp = {st_rpc[31:2], 2'b00};
            end else if (acc) begin
                m_fpc = m_fpc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic run_until_log(input int need, input int budget);
        for (int i = 0; i < budget && deq_log.size() < need; i++) step();
        chk("log_progress", 32'(deq_log.size() >= need), 32'd1);
    endtask

    initial begin
        st_rstn = 1'b0; st_stall = 1'b0; st_flush = 1'b0; st_redir = 1'b0;
        st_ready = 1'b1; st_rpc = 32'h0;
        rst_n = 1'b0;
        bus.if_stall = 1'b0; bus.if_flush = 1'b0; bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0; bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
        m_fpc = RESET_PC; m_exp = RESET_PC; hold_v = 1'b0;
        hold_pc = 32'h0; hold_instr = 32'h0;

        repeat (3) step();

        // boot: latency-1 memory, full-rate streaming
        st_rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 0) chk("boot_req_valid_k0", 32'(s_req_valid), 32'd0);
            if (k == 1) begin
                chk("boot_req_valid_k1", 32'(s_req_valid), 32'd1);
                chk("boot_addr_k1", s_req_addr, 32'h0);
            end
            if (k == 2) chk("boot_addr_k2", s_req_addr, 32'h4);
            if (k == 3) begin
                chk("boot_addr_k3", s_req_addr, 32'h8);
                chk("boot_id_valid_k3", 32'(s_id_valid), 32'd1);
                chk("boot_id_pc_k3", s_id_pc, 32'h0);
            end
            if (k == 4) chk("boot_id_pc_k4", s_id_pc, 32'h4);
            if (k == 5) chk("boot_id_pc_k5", s_id_pc, 32'h8);
            if (k >= 1) chk("boot_full_rate", 32'(s_req_valid), 32'd1);
        end

        // stall for 4 cycles while streaming
        st_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_id_pc", s_id_pc, 32'h14);
            chk("stall_id_valid", 32'(s_id_valid), 32'd1);
            if (i >= 1) chk("stall_req_valid", 32'(s_req_valid), 32'd0);
        end
        st_stall = 1'b0;
        deq_log.delete();
        repeat (2) step();
        run_until_log(2, 10);
        if (deq_log.size() >= 2) begin
            chk("unstall_pc0", deq_log[0], 32'h14);
            chk("unstall_pc1", deq_log[1], 32'h18);
        end

        // redirect with latency-2 memory, work in flight
        lat = 2;
        repeat (6) step();
        st_redir = 1'b1; st_rpc = 32'h100;
        step();
        chk("redir_id_valid", 32'(s_id_valid), 32'd0);
        st_redir = 1'b0;
        deq_log.delete();
        run_until_log(2, 20);
        if (deq_log.size() >= 2) begin
            chk("redir_pc0", deq_log[0], 32'h100);
            chk("redir_pc1", deq_log[1], 32'h104);
        end

        // memory not ready for 3 cycles
        lat = 1;
        repeat (4) step();
        st_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("notready_req_valid", 32'(s_req_valid), 32'd1);
        end
        st_ready = 1'b1;

        // address wrap, misaligned target bits ignored
        st_flush = 1'b1; st_rpc = 32'hFFFF_FFFA;
        step();
        st_flush = 1'b0;
        deq_log.delete();
        run_until_log(3, 20);
        if (deq_log.size() >= 3) begin
            chk("wrap_pc0", deq_log[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", deq_log[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", deq_log[2], 32'h0000_0000);
        end

        // randomized traffic
        deq_log.delete();
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) lat = int'($urandom_range(1, 3));
            st_stall = ($urandom % 4) == 0;
            st_flush = ($urandom % 40) == 0;
            st_redir = ($urandom % 40) == 0;
            st_rpc   = $urandom;
            st_ready = ($urandom % 10) < 7;
            step();
        end
        chk("random_progress", 32'(deq_log.size() > 200), 32'd1);

        // reset asserted mid-operation
        st_stall = 1'b0; st_flush = 1'b0; st_redir = 1'b0; st_ready = 1'b1; lat = 1;
        st_rstn = 1'b0;
        repeat (2) step();
        st_rstn = 1'b1;
        deq_log.delete();
        run_until_log(3, 12);
        if (deq_log.size() >= 3) chk("rerun_pc2", deq_log[2], 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
